// File: rtl/wide_bus_beat_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wide_bus_beat_arbiter_if
// Description : Requester-side and IP-side signal bundle for the wide bus
//               beat arbiter. "slave" is the arbiter view; "master" is the
//               view of the environment (requesters plus IP side).
// Revision    : 1.0 - initial release
// ============================================================================
interface wide_bus_beat_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int BEAT_W  = 128,
    parameter int BEATS   = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*BEAT_W-1:0] req_beat_data;
    logic [NUM_REQ-1:0]        req_beat_valid;
    logic [NUM_REQ-1:0]        req_beat_ready;
    logic [NUM_REQ-1:0]        grant;
    logic [BEAT_W*BEATS-1:0]   wide_bus_data;
    logic                      wide_bus_valid;
    logic                      wide_bus_ready;
    logic [BEATS-1:0]          wide_bus_parity;
    logic                      busy;
    logic                      timeout_err;

    modport slave (
        input  req_valid, req_beat_data, req_beat_valid, wide_bus_ready,
        output req_beat_ready, grant, wide_bus_data, wide_bus_valid,
               wide_bus_parity, busy, timeout_err
    );

    modport master (
        output req_valid, req_beat_data, req_beat_valid, wide_bus_ready,
        input  req_beat_ready, grant, wide_bus_data, wide_bus_valid,
               wide_bus_parity, busy, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/wide_bus_beat_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wide_bus_beat_arbiter
// Description : Round-robin arbiter that grants the ultra-wide IP bus to one
//               requester at a time, assembles BEATS beats of BEAT_W bits
//               into one wide word and offers it with valid/ready. A stalled
//               owner is dropped after TIMEOUT idle cycles.
//               Optional macro WIDE_BUS_PARITY_EN adds per-beat even parity;
//               without it wide_bus_parity is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module wide_bus_beat_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int BEAT_W  = 128,
    parameter int BEATS   = 8,
    parameter int TIMEOUT = 64
) (
    input  wire logic              main_clk_100mhz,
    input  wire logic              reset,
    wide_bus_beat_arbiter_if.slave bus
);

    localparam int c_wide_w = BEAT_W * BEATS;
    localparam int c_idx_w  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_cnt_w  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int c_tmo_w  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_collect = 2'd1;
    localparam logic [1:0] c_st_present = 2'd2;

    logic [1:0]          r_state,      w_state_nxt;
    logic [NUM_REQ-1:0]  r_grant,      w_grant_nxt;
    logic [c_idx_w-1:0]  r_owner,      w_owner_nxt;
    logic [c_idx_w-1:0]  r_last_owner, w_last_owner_nxt;
    logic [c_cnt_w-1:0]  r_beat_cnt,   w_beat_cnt_nxt;
    logic [c_tmo_w-1:0]  r_idle_cnt,   w_idle_cnt_nxt;
    logic [c_wide_w-1:0] r_data,       w_data_nxt;
    logic                r_valid,      w_valid_nxt;
    logic                r_timeout,    w_timeout_nxt;
    logic                r_busy;

    logic                w_any_req;
    logic [c_idx_w-1:0]  w_pick;
    logic [BEAT_W-1:0]   w_beat;
    logic                w_beat_acc;

    assign w_beat     = bus.req_beat_data[int'(r_owner) * BEAT_W +: BEAT_W];
    assign w_beat_acc = (r_state == c_st_collect) && bus.req_beat_valid[r_owner];

    // Round-robin pick: first requesting index after the last owner, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        w_any_req = 1'b0;
        w_pick    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(r_last_owner) + off) % NUM_REQ;
            if (!w_any_req && bus.req_valid[idx]) begin
                w_any_req = 1'b1;
                w_pick    = c_idx_w'(idx);
            end
        end
    end

    // Next-state and datapath decode for IDLE / COLLECT / PRESENT.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_beat_cnt_nxt   = r_beat_cnt;
        w_idle_cnt_nxt   = r_idle_cnt;
        w_data_nxt       = r_data;
        w_valid_nxt      = r_valid;
        w_timeout_nxt    = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_beat_cnt_nxt = '0;
                w_idle_cnt_nxt = '0;
                if (w_any_req) begin
                    w_grant_nxt         = '0;
                    w_grant_nxt[w_pick] = 1'b1;
                    w_owner_nxt         = w_pick;
                    w_state_nxt         = c_st_collect;
                end
            end
            c_st_collect: begin
                if (w_beat_acc) begin
                    w_data_nxt[int'(r_beat_cnt) * BEAT_W +: BEAT_W] = w_beat;
                    w_idle_cnt_nxt = '0;
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    if (r_beat_cnt == c_cnt_w'(BEATS - 1)) begin
                        w_beat_cnt_nxt = '0;
                        w_valid_nxt    = 1'b1;
                        w_state_nxt    = c_st_present;
                    end
                end else if (r_idle_cnt == c_tmo_w'(TIMEOUT - 1)) begin
                    // This edge brings the idle count to TIMEOUT: abandon the owner.
                    w_timeout_nxt    = 1'b1;
                    w_grant_nxt      = '0;
                    w_last_owner_nxt = r_owner;
                    w_state_nxt      = c_st_idle;
                end else begin
                    w_idle_cnt_nxt = r_idle_cnt + 1'b1;
                end
            end
            c_st_present: begin
                // A ready seen during the final COLLECT beat never reaches here.
                if (bus.wide_bus_ready) begin
                    w_valid_nxt      = 1'b0;
                    w_grant_nxt      = '0;
                    w_last_owner_nxt = r_owner;
                    w_state_nxt      = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // State and registered-output update; reset drops any partial word.
    always_ff @(posedge main_clk_100mhz) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= c_idx_w'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
            r_idle_cnt   <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_beat_cnt   <= w_beat_cnt_nxt;
            r_idle_cnt   <= w_idle_cnt_nxt;
            r_data       <= w_data_nxt;
            r_valid      <= w_valid_nxt;
            r_timeout    <= w_timeout_nxt;
            r_busy       <= (w_state_nxt != c_st_idle);
        end
    end

`ifdef WIDE_BUS_PARITY_EN
    logic [BEATS-1:0] r_parity;

    // Capture even parity of each beat as it is accepted.
    always_ff @(posedge main_clk_100mhz) begin
        if (reset) begin
            r_parity <= '0;
        end else if (w_beat_acc) begin
            r_parity[r_beat_cnt] <= ^w_beat;
        end
    end

    assign bus.wide_bus_parity = r_parity;
`else
    assign bus.wide_bus_parity = '0;
`endif

    // Ready is the only combinational output: owner bit while collecting.
    assign bus.req_beat_ready = (r_state == c_st_collect) ? r_grant : '0;
    assign bus.grant          = r_grant;
    assign bus.wide_bus_data  = r_data;
    assign bus.wide_bus_valid = r_valid;
    assign bus.busy           = r_busy;
    assign bus.timeout_err    = r_timeout;

endmodule
`default_nettype wire

// File: doc/wide_bus_beat_arbiter.md
# wide_bus_beat_arbiter

Round-robin arbiter and beat sequencer that shares the 1024-bit ultra-wide input bus of the unicode edge IP among several requesters. Each granted requester supplies its word as 128-bit beats. The block assembles the beats into one wide word and presents it to the IP side with a valid/ready handshake. It sits in the top level between the external requesters and the IP's ultra-wide bus port.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8)
- BEAT_W, 128: beat width in bits
- BEATS, 8: beats per wide word; wide width WIDE_W = BEAT_W*BEATS = 1024
- TIMEOUT, 64: max idle cycles between beats during collection (≥2)

Ports:
- main_clk_100mhz  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i requests the bus
- req_beat_data  in  NUM_REQ*BEAT_W  beat data; requester i at [i*BEAT_W +: BEAT_W]
- req_beat_valid  in  NUM_REQ  beat valid per requester
- req_beat_ready  out  NUM_REQ  beat ready; only the granted bit can be 1
- grant  out  NUM_REQ  one-hot current owner, 0 when idle
- wide_bus_data  out  WIDE_W  assembled word
- wide_bus_valid  out  1  assembled word valid
- wide_bus_ready  in  1  IP side accepts word
- wide_bus_parity  out  BEATS  per-beat even parity (see Configuration)
- busy  out  1  state ≠ IDLE
- timeout_err  out  1  one-cycle pulse on collection abort

## Operation
- FSM states: IDLE, COLLECT, PRESENT.
- IDLE:
  - If any req_valid is set, select the first set bit scanning upward from (last_owner+1) mod NUM_REQ, with wrap.
  - Register the choice in grant and go to COLLECT.
  - beat_cnt and the idle counter clear to 0.
- COLLECT:
  - req_beat_ready[owner] = 1.
  - On req_beat_valid[owner]: beat k is written to wide_bus_data[k*BEAT_W +: BEAT_W], beat_cnt++, idle counter clears.
  - Beats from non-owners are ignored.
  - On the acceptance of beat BEATS-1, go to PRESENT.
  - Deasserting req_valid mid-collection is ignored.
  - If the idle counter reaches TIMEOUT: pulse timeout_err, clear grant, set last_owner = owner, return to IDLE, and leave wide_bus_data undefined-but-stable.
- PRESENT:
  - wide_bus_valid = 1; data and grant held stable.
  - On wide_bus_ready: last_owner = owner, clear grant, go to IDLE.
- Reset values:
  - grant = 0, req_beat_ready = 0, wide_bus_valid = 0, wide_bus_data = 0, wide_bus_parity = 0, busy = 0, timeout_err = 0.
  - last_owner = NUM_REQ-1, so requester 0 has first priority.
- Reset asserted in any state returns to IDLE on the next edge. Partial beats are discarded; no timeout_err pulse.

## Timing
- All outputs are registered except req_beat_ready, which is decoded from state and grant.
- With req_valid set in IDLE at cycle 0, grant is set at cycle 1 and req_beat_ready is 1 from cycle 1.
- With beats every cycle, beats are accepted at cycles 1..BEATS and wide_bus_valid rises at cycle BEATS+1. That is 9 cycles for the default parameters.
- When wide_bus_ready is sampled at cycle t, the block is IDLE at t+1 and the next grant appears at t+2. Minimum period per word is BEATS+2 cycles.
- The idle counter increments each COLLECT cycle without an owner beat. A timeout fires on the edge where the count equals TIMEOUT, and timeout_err is high during the following cycle.
- If wide_bus_ready is high in the same cycle the final beat is accepted, it has no effect. The handshake is only evaluated in PRESENT.

## Configuration
- WIDE_BUS_PARITY_EN defined:
  - On each beat acceptance, wide_bus_parity[k] is registered as the XOR-reduction of beat k.
  - Valid alongside wide_bus_valid.
- Undefined:
  - No parity logic; wide_bus_parity is tied to 0.
  - Port list unchanged.

## Test plan
- Single requester: req_valid=0001, beats 0x…00..0x…07 back-to-back. Expect grant=0001 at cycle 1 and wide_bus_valid at cycle 9. wide_bus_data[k*128 +: 128] equals beat k. After ready, grant=0.
- Round robin: req_valid=1111 held for 4 words with ready tied high. Expect grant order 0001, 0010, 0100, 1000, and 10-cycle spacing between grants.
- Backpressure: wide_bus_ready low for 20 cycles in PRESENT. Expect data/valid/grant stable, no new grant, and IDLE one cycle after ready rises.
- Timeout: owner 2 sends 3 beats then stalls. Expect timeout_err pulse exactly TIMEOUT cycles after the last beat, then grant=1000 next if req_valid=1100.
- Reset mid-COLLECT after 5 beats: all outputs return to reset values the next cycle and no timeout_err. The next grant goes to requester 0 when req_valid=1111.
- Parity (macro defined): beat 3 = 128'h1, others 0. Expect wide_bus_parity = 8'b0000_1000. With the macro undefined, expect 0.
